// File: rtl/vic_sound_pkg.sv
// Shared constants and width helpers for the parametrised VIC sound generator.
// Voices, prescaler and mixer all import this package.
package vic_sound_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int AMP_W = 4;

  function automatic int calc_aw(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  function automatic int calc_out_w(input int n_ch);
    return $clog2(n_ch + 1) + AMP_W;
  endfunction

endpackage

// File: rtl/vic_sound_voice.sv
// One sound voice: an up-counter reloaded from the control byte on overflow.
// On each overflow event the output toggles (tone) or takes the next LFSR bit (noise).
module vic_sound_voice
  import vic_sound_pkg::*;
#(
  parameter int FREQ_W   = 7,
  parameter bit IS_NOISE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [FREQ_W:0]   ctl,
  input  logic              load,
  input  logic [FREQ_W-1:0] load_freq,
  output logic              ch
);

  logic              enable;
  logic [FREQ_W-1:0] freq;
  logic [FREQ_W-1:0] cnt;
  logic              fire;
  logic              noise_bit;

  assign enable = ctl[FREQ_W];
  assign freq   = ctl[FREQ_W-1:0];
  assign fire   = enable & tick & (&cnt);

  generate
    if (IS_NOISE) begin : g_noise
      logic [LFSR_W-1:0] lfsr;
      logic              fb;

      assign fb        = ^(lfsr & LFSR_TAPS);
      assign noise_bit = (lfsr == '0) ? LFSR_SEED[0] : fb;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lfsr <= LFSR_SEED;
        end else if (fire) begin
          lfsr <= (lfsr == '0) ? LFSR_SEED : {lfsr[LFSR_W-2:0], fb};
        end
      end
    end else begin : g_tone
      assign noise_bit = 1'b0;
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ch  <= 1'b0;
    end else if (!enable) begin
      // An enabling write in this cycle must start the count from its new F.
      cnt <= load ? load_freq : freq;
      ch  <= 1'b0;
    end else if (tick) begin
      if (&cnt) begin
        cnt <= freq;
        ch  <= IS_NOISE ? noise_bit : ~ch;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vic_sound_gen.sv
// Parametrised VIC sound path: CPU register file with read-back, octave
// prescaler, N_CH tone/noise voices and an amplitude-scaled popcount mixer.
module vic_sound_gen
  import vic_sound_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter bit NOISE_EN = 1'b1,
  parameter int PRE_LOG2 = 4,
  parameter int FREQ_W   = 7,
  parameter int AW       = calc_aw(N_CH),
  parameter int OUT_W    = calc_out_w(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ena,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [FREQ_W:0]  i_wdata,
  output logic [FREQ_W:0]  o_rdata,
  output logic [N_CH-1:0]  o_ch,
  output logic [OUT_W-1:0] o_audio
);

  localparam int PRE_W = PRE_LOG2 + N_CH - 1;
  localparam int CW    = FREQ_W + 1;

  logic [FREQ_W:0]   ctl [N_CH];
  logic [AMP_W-1:0]  amp;
  logic [PRE_W-1:0]  pre;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   load;
  logic [FREQ_W:0]   rdata_next;
  logic [OUT_W-1:0]  active;
  logic [OUT_W-1:0]  mix;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_voice
      // Channel k needs one more low prescaler bit of ones than channel k+1.
      assign tick[k] = i_ena & (&pre[PRE_W-1-k:0]);
      assign load[k] = i_we && (i_addr == AW'(k));

      vic_sound_voice #(
        .FREQ_W   (FREQ_W),
        .IS_NOISE (NOISE_EN && (k == N_CH - 1))
      ) u_voice (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .tick      (tick[k]),
        .ctl       (ctl[k]),
        .load      (load[k]),
        .load_freq (i_wdata[FREQ_W-1:0]),
        .ch        (o_ch[k])
      );
    end
  endgenerate

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rdata_next = '0;
    if (i_addr == AW'(N_CH)) rdata_next = CW'(amp);
    for (int k = 0; k < N_CH; k++) begin
      if (i_addr == AW'(k)) rdata_next = ctl[k];
    end
  end

  always_comb begin
    active = '0;
    for (int k = 0; k < N_CH; k++) begin
      active = active + OUT_W'(o_ch[k]);
    end
    mix = active * OUT_W'(amp);
  end

  // NOTE: the control register file is small and must read back as zero after
  // reset, so it is reset explicitly rather than left as uninitialised RAM.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_CH; k++) ctl[k] <= '0;
      amp     <= '0;
      pre     <= '0;
      o_rdata <= '0;
      o_audio <= '0;
    end else begin
      if (i_ena) pre <= pre + 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (load[k]) ctl[k] <= i_wdata;
      end
      if (i_we && (i_addr == AW'(N_CH))) amp <= i_wdata[AMP_W-1:0];
      o_rdata <= rdata_next;
      o_audio <= mix;
    end
  end

endmodule

// File: tb/tb_vic_sound_gen.sv
// Self-checking bench for vic_sound_gen: a tick-countdown reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_vic_sound_gen;

  localparam int N_CH     = 4;
  localparam int PRE_LOG2 = 4;
  localparam int FREQ_W   = 7;
  localparam int AW       = 3;
  localparam int OUT_W    = 7;
  localparam int LIMIT    = 700;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_ena;
  logic             i_we;
  logic [AW-1:0]    i_addr;
  logic [FREQ_W:0]  i_wdata;
  logic [FREQ_W:0]  o_rdata;
  logic [N_CH-1:0]  o_ch;
  logic [OUT_W-1:0] o_audio;

  vic_sound_gen #(
    .N_CH     (N_CH),
    .NOISE_EN (1'b1),
    .PRE_LOG2 (PRE_LOG2),
    .FREQ_W   (FREQ_W)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ena     (i_ena),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_ch      (o_ch),
    .o_audio   (o_audio)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference model: each channel counts down ticks remaining to its next event.
  int m_ctl [N_CH];
  int m_left[N_CH];
  int m_ch  [N_CH];
  int m_amp, m_lfsr, m_audio, m_rdata, ena_idx;
  int t_ones, t_audio, t_rdata, t_addr, t_f, t_nb, t_period;
  bit model_valid = 1'b0;

  always @(posedge i_clk) begin
    cyc_cnt++;
    if (!i_reset_n) begin
      for (int k = 0; k < N_CH; k++) begin
        m_ctl[k] = 0; m_left[k] = 128; m_ch[k] = 0;
      end
      m_amp = 0; m_lfsr = 1; m_audio = 0; m_rdata = 0; ena_idx = 0;
      model_valid = 1'b1;
    end else begin
      t_ones = 0;
      for (int k = 0; k < N_CH; k++) t_ones += m_ch[k];
      t_audio = t_ones * m_amp;
      t_addr  = int'(i_addr);
      t_rdata = (t_addr < N_CH) ? m_ctl[t_addr] : (t_addr == N_CH) ? m_amp : 0;
      for (int k = 0; k < N_CH; k++) begin
        t_f = m_ctl[k] % 128;
        t_period = 1 << (PRE_LOG2 + N_CH - 1 - k);
        if (m_ctl[k] < 128) begin
          if (i_we && t_addr == k) t_f = int'(i_wdata) % 128;
          m_left[k] = 128 - t_f;
          m_ch[k] = 0;
        end else if (i_ena && ((ena_idx + 1) % t_period) == 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_left[k] = 128 - t_f;
            if (k == N_CH - 1) begin
              if (m_lfsr == 0) begin
                m_lfsr = 1; m_ch[k] = 1;
              end else begin
                t_nb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
                m_lfsr = ((m_lfsr << 1) | t_nb) & 'hFFFF;
                m_ch[k] = t_nb;
              end
            end else begin
              m_ch[k] = 1 - m_ch[k];
            end
          end
        end
      end
      if (i_ena) ena_idx++;
      if (i_we) begin
        if (t_addr < N_CH) m_ctl[t_addr] = int'(i_wdata);
        else if (t_addr == N_CH) m_amp = int'(i_wdata) % 16;
      end
      m_audio = t_audio;
      m_rdata = t_rdata;
    end
  end

  always @(negedge i_clk) begin
    if (model_valid) begin
      logic [N_CH-1:0] exp_ch;
      for (int k = 0; k < N_CH; k++) exp_ch[k] = m_ch[k][0];
      check("model_o_ch", 32'(o_ch), 32'(exp_ch));
      check("model_o_audio", 32'(o_audio), 32'(m_audio));
      check("model_o_rdata", 32'(o_rdata), 32'(m_rdata));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wr(input int addr, input int data);
    i_we = 1'b1; i_addr = AW'(addr); i_wdata = 8'(data);
    @(negedge i_clk);
    i_we = 1'b0;
  endtask

  task automatic wait_toggle(input int k, output int t);
    logic prev;
    int n;
    prev = o_ch[k];
    n = 0;
    while (o_ch[k] === prev && n < LIMIT) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= LIMIT) check("toggle_wait_timeout", 32'(n), 32'(0));
    t = cyc_cnt;
  endtask

  task automatic wait_high(input int k);
    int n;
    n = 0;
    while (o_ch[k] !== 1'b1 && n < LIMIT) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= LIMIT) check("high_wait_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int t0, t1, t2, t3, n;

    // Reset dominates a write and enable held in the same cycles.
    i_reset_n = 1'b0; i_ena = 1'b1; i_we = 1'b1; i_addr = '0; i_wdata = 8'hFF;
    step(3);
    check("reset_o_ch", 32'(o_ch), 32'h0);
    check("reset_o_audio", 32'(o_audio), 32'h0);
    check("reset_o_rdata", 32'(o_rdata), 32'h0);
    i_reset_n = 1'b1; i_we = 1'b0; i_ena = 1'b0;
    step(1);
    check("read_addr0_after_reset", 32'(o_rdata), 32'h0);

    // Noise: LFSR from 0001 gives ten zeros, then its first one on the 11th event.
    wr(3, 'hFF);
    i_ena = 1'b1;
    step(175);
    check("noise_before_event11", 32'(o_ch[3]), 32'h0);
    step(1);
    check("noise_event11", 32'(o_ch[3]), 32'h1);
    step(1);
    check("noise_amp0_audio", 32'(o_audio), 32'h0);
    wr(3, 'h00);

    // Tone on ch2 at F=0x7E: toggle every 64 cycles.
    wr(4, 15);
    wr(2, 'hFE);
    wait_toggle(2, t0);
    wait_toggle(2, t1);
    wait_toggle(2, t2);
    wait_toggle(2, t3);
    check("tone_gap1", 32'(t1 - t0), 32'd64);
    check("tone_gap2", 32'(t2 - t1), 32'd64);
    check("tone_gap3", 32'(t3 - t2), 32'd64);
    wait_high(2);
    step(1);
    check("tone_audio_15", 32'(o_audio), 32'd15);

    // Octaves: every tick fires, so ch2/ch1/ch0 toggle every 32/64/128.
    wr(0, 'hFF);
    wr(1, 'hFF);
    wr(2, 'hFF);
    wait_toggle(2, t0); wait_toggle(2, t1); wait_toggle(2, t2);
    check("octave_ch2_gap", 32'(t2 - t1), 32'd32);
    wait_toggle(1, t0); wait_toggle(1, t1); wait_toggle(1, t2);
    check("octave_ch1_gap", 32'(t2 - t1), 32'd64);
    wait_toggle(0, t0); wait_toggle(0, t1); wait_toggle(0, t2);
    check("octave_ch0_gap", 32'(t2 - t1), 32'd128);
    n = 0;
    while (o_ch[2:0] !== 3'b111 && n < LIMIT) begin
      step(1);
      n++;
    end
    if (n >= LIMIT) check("all_high_timeout", 32'(n), 32'(0));
    step(1);
    check("octave_audio_45", 32'(o_audio), 32'd45);

    // Disable mid-run, then re-enable: first toggle after two ch2 ticks.
    wait_high(2);
    wr(2, 'h7E);
    step(1);
    check("disable_ch2_low", 32'(o_ch[2]), 32'h0);
    check("disable_read_f", 32'(o_rdata), 32'h7E);
    wr(2, 'hFE);
    n = 1;
    while (o_ch[2] !== 1'b1 && n < LIMIT) begin
      step(1);
      n++;
    end
    check("reenable_window", 32'(n > 32 && n <= 64), 32'h1);

    // Out-of-range address: write ignored, reads as zero.
    wr(5, 'hAA);
    i_addr = 3'd0; step(1); check("read_ctl0", 32'(o_rdata), 32'hFF);
    i_addr = 3'd1; step(1); check("read_ctl1", 32'(o_rdata), 32'hFF);
    i_addr = 3'd2; step(1); check("read_ctl2", 32'(o_rdata), 32'hFE);
    i_addr = 3'd3; step(1); check("read_ctl3", 32'(o_rdata), 32'h00);
    i_addr = 3'd4; step(1); check("read_amp", 32'(o_rdata), 32'h0F);
    i_addr = 3'd5; step(1); check("read_addr5", 32'(o_rdata), 32'h00);
    i_addr = 3'd7; step(1); check("read_addr7", 32'(o_rdata), 32'h00);

    // Reset while channels run: next cycle everything is zero.
    i_reset_n = 1'b0;
    step(1);
    check("midreset_o_ch", 32'(o_ch), 32'h0);
    check("midreset_o_audio", 32'(o_audio), 32'h0);
    check("midreset_o_rdata", 32'(o_rdata), 32'h0);
    i_reset_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
